// File: rtl/div_share_arb.sv
// div_share_arb: round-robin scheduler that shares one sequential divider
// between N_REQ requesters. It latches the winner's operands, pulses the
// divider start, waits for end-of-operation and returns the quotient.
// Optional feature macro: DIV_ARB_TIMEOUT_EN (abort WAIT after TMO cycles).
module div_share_arb #(
   parameter int N_REQ = 4,
   parameter int W     = 16,
   parameter int TMO   = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] num_in,
   input  logic [N_REQ*W-1:0] den_in,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [W-1:0]       q_out,
   output logic               err,
   output logic               busy,
   output logic               div_st,
   output logic [W-1:0]       div_num,
   output logic [W-1:0]       div_den,
   input  logic               div_eo,
   input  logic [W-1:0]       div_q
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

   // parameter sanity: nothing is built for a legal configuration
   if (N_REQ < 2 || N_REQ > 8 || TMO < 1) begin : g_param_err
   end

   state_t         r_state, w_next;
   logic [IW-1:0]  r_ptr, r_g, w_pick;
   logic [IW:0]    w_sum;
   logic           w_found;
   logic [W-1:0]   r_num, r_den, r_q;
   logic           r_err;
   logic [N_REQ-1:0] w_onehot;
   logic           w_den_zero;

   assign w_den_zero = (r_den == '0);

`ifdef DIV_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TMO + 1);
   logic [CW-1:0] r_cnt;
   logic          w_tmo;
   assign w_tmo = (r_cnt == CW'(TMO - 1));

   // WAIT cycle counter: cleared on the way into WAIT, +1 each WAIT cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_cnt <= '0;
      else if (r_state == S_LOAD) r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
   end
`endif

   // round-robin pick: first set request scanning ptr, ptr+1, ... (mod N_REQ)
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(N_REQ)) w_sum = w_sum - (IW+1)'(N_REQ);
         if (!w_found && req[w_sum[IW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_sum[IW-1:0];
         end
      end
   end

   // next-state logic; div_eo only matters in WAIT and wins over a timeout
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_found) w_next = S_LOAD;
         S_LOAD: w_next = w_den_zero ? S_DONE : S_WAIT;
         S_WAIT: begin
            if (div_eo) w_next = S_DONE;
`ifdef DIV_ARB_TIMEOUT_EN
            else if (w_tmo) w_next = S_DONE;
`endif
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // operand latch, result/err capture and round-robin pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
         r_g   <= '0;
         r_num <= '0;
         r_den <= '0;
         r_q   <= '0;
         r_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_found) begin
               r_g   <= w_pick;
               r_num <= num_in[w_pick*W +: W];
               r_den <= den_in[w_pick*W +: W];
            end
            S_LOAD: if (w_den_zero) begin
               r_q   <= '1;
               r_err <= 1'b1;
            end
            S_WAIT: begin
               if (div_eo) begin
                  r_q   <= div_q;
                  r_err <= 1'b0;
               end
`ifdef DIV_ARB_TIMEOUT_EN
               else if (w_tmo) begin
                  r_q   <= '0;
                  r_err <= 1'b1;
               end
`endif
            end
            S_DONE: r_ptr <= (r_g == IW'(N_REQ - 1)) ? '0 : r_g + 1'b1;
            default: ;
         endcase
      end
   end

   // Moore outputs decoded from registered state
   assign w_onehot = N_REQ'(1) << r_g;
   assign gnt      = (r_state != S_IDLE) ? w_onehot : '0;
   assign done     = (r_state == S_DONE) ? w_onehot : '0;
   assign err      = (r_state == S_DONE) & r_err;
   assign busy     = (r_state != S_IDLE);
   assign div_st   = (r_state == S_LOAD) & ~w_den_zero;
   assign div_num  = r_num;
   assign div_den  = r_den;
   assign q_out    = r_q;

endmodule

// File: tb/tb_div_share_arb.sv
// Directed self-checking bench for div_share_arb (N_REQ=4, W=16, TMO=8).
module tb_div_share_arb;
   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] num_in, den_in;
   logic [N-1:0]   gnt, done;
   logic [W-1:0]   q_out, div_num, div_den, div_q;
   logic           err, busy, div_st, div_eo;

   int checks = 0;
   int failures = 0;

   div_share_arb #(.N_REQ(N), .W(W), .TMO(8)) dut (
      .clk(clk), .rst(rst), .req(req), .num_in(num_in), .den_in(den_in),
      .gnt(gnt), .done(done), .q_out(q_out), .err(err), .busy(busy),
      .div_st(div_st), .div_num(div_num), .div_den(div_den),
      .div_eo(div_eo), .div_q(div_q)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; div_eo = 1'b0; div_q = '0;
      num_in = '0; den_in = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; div_eo = 1'b0; div_q = '0; num_in = '0; den_in = '0;
      #3;
      checks++;
      if ({gnt, done, q_out, err, busy, div_st, div_num, div_den} !== '0) begin
         failures++;
         $display("FAIL reset_outputs gnt=%b done=%b q=%h err=%b busy=%b st=%b num=%h den=%h",
                  gnt, done, q_out, err, busy, div_st, div_num, div_den);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      req = 4'b0001; num_in[0 +: W] = 16'd100; den_in[0 +: W] = 16'd7;
      step(); // LOAD
      checks++;
      if ({gnt, div_st, busy, div_num, div_den} !== {4'b0001, 1'b1, 1'b1, 16'd100, 16'd7}) begin
         failures++;
         $display("FAIL basic_load gnt=%b st=%b busy=%b num=%0d den=%0d exp 0001 1 1 100 7",
                  gnt, div_st, busy, div_num, div_den);
      end
      step(); // WAIT
      checks++;
      if (div_st !== 1'b0 || gnt !== 4'b0001) begin
         failures++;
         $display("FAIL basic_st_one_cycle st=%b gnt=%b exp 0 0001", div_st, gnt);
      end
      for (int i = 0; i < 3; i++) step();
      div_eo = 1'b1; div_q = 16'd14;
      step(); // DONE
      checks++;
      if ({done, q_out, err} !== {4'b0001, 16'd14, 1'b0}) begin
         failures++;
         $display("FAIL basic_done done=%b q=%0d err=%b exp 0001 14 0", done, q_out, err);
      end
      div_eo = 1'b0; req = '0;
      step(); // IDLE
      checks++;
      if ({done, gnt, busy, q_out} !== {4'b0000, 4'b0000, 1'b0, 16'd14}) begin
         failures++;
         $display("FAIL basic_idle done=%b gnt=%b busy=%b q=%0d exp 0 0 0 14", done, gnt, busy, q_out);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_g [3];
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001;
      do_reset();
      req = 4'b0101;
      num_in[0 +: W] = 16'd20; den_in[0 +: W] = 16'd4;
      num_in[2*W +: W] = 16'd30; den_in[2*W +: W] = 16'd3;
      for (int r = 0; r < 3; r++) begin
         step(); // LOAD
         checks++;
         if (gnt !== exp_g[r]) begin
            failures++;
            $display("FAIL rr_grant_%0d gnt=%b exp %b", r, gnt, exp_g[r]);
         end
         step(); // WAIT
         checks++;
         if ($countones(gnt) > 1) begin
            failures++;
            $display("FAIL rr_twohot_%0d gnt=%b", r, gnt);
         end
         div_eo = 1'b1; div_q = 16'd5 + 16'(r);
         step(); // DONE
         checks++;
         if ({done, q_out} !== {exp_g[r], 16'd5 + 16'(r)}) begin
            failures++;
            $display("FAIL rr_done_%0d done=%b q=%0d exp %b %0d", r, done, q_out, exp_g[r], 5 + r);
         end
         div_eo = 1'b0;
         step(); // IDLE: exactly one cycle between ops
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle_%0d busy=%b exp 0", r, busy);
         end
      end
      req = '0;
      step();
   endtask

   task automatic test_div_zero();
      do_reset();
      req = 4'b0010; num_in[W +: W] = 16'd55; den_in[W +: W] = 16'd0;
      step(); // LOAD
      checks++;
      if ({gnt, div_st} !== {4'b0010, 1'b0}) begin
         failures++;
         $display("FAIL dz_load gnt=%b st=%b exp 0010 0", gnt, div_st);
      end
      step(); // DONE
      checks++;
      if ({done, q_out, err} !== {4'b0010, 16'hFFFF, 1'b1}) begin
         failures++;
         $display("FAIL dz_done done=%b q=%h err=%b exp 0010 ffff 1", done, q_out, err);
      end
      req = '0;
      step();
      checks++;
      if ({err, done} !== 5'b0) begin
         failures++;
         $display("FAIL dz_err_clear err=%b done=%b exp 0 0000", err, done);
      end
   endtask

   task automatic test_wait_hold();
      int got_done;
      do_reset();
      req = 4'b0100; num_in[2*W +: W] = 16'd9; den_in[2*W +: W] = 16'd3;
      step(); step(); // LOAD, WAIT
      got_done = 0;
      for (int i = 0; i < 7; i++) begin
         step();
         if (done !== 4'b0000) got_done++;
      end
`ifdef DIV_ARB_TIMEOUT_EN
      // 8th WAIT cycle ends by timeout
      checks++;
      if (got_done != 0) begin
         failures++;
         $display("FAIL tmo_early done_cycles=%0d exp 0", got_done);
      end
      step();
      checks++;
      if ({done, q_out, err} !== {4'b0100, 16'd0, 1'b1}) begin
         failures++;
         $display("FAIL tmo_done done=%b q=%h err=%b exp 0100 0000 1", done, q_out, err);
      end
      req = 4'b0001; num_in[0 +: W] = 16'd8; den_in[0 +: W] = 16'd2;
      step(); step(); step(); // IDLE, LOAD, WAIT
      div_eo = 1'b1; div_q = 16'd4;
      step();
      checks++;
      if ({done, q_out, err} !== {4'b0001, 16'd4, 1'b0}) begin
         failures++;
         $display("FAIL tmo_next done=%b q=%0d err=%b exp 0001 4 0", done, q_out, err);
      end
`else
      for (int i = 0; i < 20; i++) begin
         step();
         if (done !== 4'b0000) got_done++;
      end
      checks++;
      if (got_done != 0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL wait_hold done_cycles=%0d busy=%b exp 0 1", got_done, busy);
      end
      div_eo = 1'b1; div_q = 16'd3;
      step();
      checks++;
      if ({done, q_out, err} !== {4'b0100, 16'd3, 1'b0}) begin
         failures++;
         $display("FAIL wait_release done=%b q=%0d err=%b exp 0100 3 0", done, q_out, err);
      end
`endif
      div_eo = 1'b0; req = '0;
      step();
   endtask

   task automatic test_reset_abort();
      do_reset();
      req = 4'b0001; num_in[0 +: W] = 16'd10; den_in[0 +: W] = 16'd2;
      step(); step();
      div_eo = 1'b1; div_q = 16'd5;
      step(); // DONE, ptr -> 1
      div_eo = 1'b0;
      step(); // IDLE
      step(); step(); // LOAD, WAIT (req0 still held)
      step();
      rst = 1'b1;
      #2;
      checks++;
      if ({gnt, done, q_out, err, busy, div_st, div_num, div_den} !== '0) begin
         failures++;
         $display("FAIL abort_outputs gnt=%b done=%b q=%h err=%b busy=%b st=%b num=%h den=%h",
                  gnt, done, q_out, err, busy, div_st, div_num, div_den);
      end
      req = 4'b0101;
      den_in[2*W +: W] = 16'd1;
      step();
      rst = 1'b0;
      checks++;
      if (done !== 4'b0000) begin
         failures++;
         $display("FAIL abort_no_done done=%b exp 0000", done);
      end
      step(); // LOAD: pointer back at 0 picks req0 over req2
      checks++;
      if (gnt !== 4'b0001) begin
         failures++;
         $display("FAIL abort_ptr gnt=%b exp 0001", gnt);
      end
      req = '0;
      step(); div_eo = 1'b1; step(); div_eo = 1'b0; step();
   endtask

   task automatic test_drop_and_load_eo();
      do_reset();
      req = 4'b0001; num_in[0 +: W] = 16'd9; den_in[0 +: W] = 16'd3;
      step(); // LOAD
      div_eo = 1'b1; div_q = 16'd77;
      step(); // WAIT: eo during LOAD was ignored
      checks++;
      if ({done, gnt, busy} !== {4'b0000, 4'b0001, 1'b1}) begin
         failures++;
         $display("FAIL load_eo_ignored done=%b gnt=%b busy=%b exp 0000 0001 1", done, gnt, busy);
      end
      div_eo = 1'b0; req = '0;
      num_in[0 +: W] = 16'd1234; den_in[0 +: W] = 16'd0;
      step(); step();
      checks++;
      if ({div_num, div_den} !== {16'd9, 16'd3}) begin
         failures++;
         $display("FAIL operand_hold num=%0d den=%0d exp 9 3", div_num, div_den);
      end
      div_eo = 1'b1; div_q = 16'd3;
      step();
      checks++;
      if ({done, q_out} !== {4'b0001, 16'd3}) begin
         failures++;
         $display("FAIL drop_done done=%b q=%0d exp 0001 3", done, q_out);
      end
      div_eo = 1'b0;
      step();
   endtask

   task automatic test_wrap();
      do_reset();
      req = 4'b1000; num_in[3*W +: W] = 16'd6; den_in[3*W +: W] = 16'd2;
      num_in[0 +: W] = 16'd6; den_in[0 +: W] = 16'd3;
      step(); step(); div_eo = 1'b1; div_q = 16'd3; step(); div_eo = 1'b0;
      req = 4'b1001;
      step(); // IDLE, ptr wrapped to 0
      step(); // LOAD
      checks++;
      if (gnt !== 4'b0001) begin
         failures++;
         $display("FAIL wrap_grant gnt=%b exp 0001", gnt);
      end
      req = '0;
      step(); div_eo = 1'b1; step(); div_eo = 1'b0; step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_div_zero();
      test_wait_hold();
      test_reset_abort();
      test_drop_and_load_eo();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
